// File: rtl/readout_pkg.sv
// Shared constants for the ADC result sequencer: frame geometry,
// channel interleave tables and the tagged FIFO entry layout.
package readout_pkg;

   localparam int PIXELS_DEF    = 128;
   localparam int NUM_ADC_DEF   = 4;
   localparam int ADC_WIDTH_DEF = 16;
   localparam int TAG_W         = 7;
   localparam int ENTRY_W       = ADC_WIDTH_DEF + TAG_W;

   // Two bits per slot, slot 0 in the LSBs.
   // CH_MAP is indexed by pixel%4, CH_BASE by channel.
   localparam logic [7:0] CH_MAP  = {2'd2, 2'd0, 2'd3, 2'd1};
   localparam logic [7:0] CH_BASE = {2'd1, 2'd3, 2'd0, 2'd2};

   function automatic logic [1:0] map_ch(input logic [1:0] slot);
      return CH_MAP[{slot, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/adc_result_sequencer_if.sv
// Sample-in and beat-out bundle of the ADC result sequencer.
// master = sequencer side, slave = ADC front end plus downstream sink.
interface adc_result_sequencer_if;
   import readout_pkg::*;

   logic [NUM_ADC_DEF-1:0]               adc_valid;
   logic [NUM_ADC_DEF*ADC_WIDTH_DEF-1:0] adc_data;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [ADC_WIDTH_DEF-1:0]             out_data;
   logic [TAG_W-1:0]                     out_index;
   logic                                 out_last;

   modport master (
      input  adc_valid, adc_data, out_ready,
      output out_valid, out_data, out_index, out_last
   );

   modport slave (
      output adc_valid, adc_data, out_ready,
      input  out_valid, out_data, out_index, out_last
   );

endinterface

// File: rtl/adc_tag_fifo.sv
// Two-entry FIFO of {sample, pixel tag}; a push into a full FIFO is
// taken only when a pop retires the head in the same cycle.
module adc_tag_fifo
   import readout_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clr,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [ENTRY_W-1:0] i_data,
   output logic [ENTRY_W-1:0] o_data,
   output logic               o_full,
   output logic               o_empty
);

   logic [ENTRY_W-1:0] r_mem [2];
   logic               r_rd;
   logic               r_wr;
   logic [1:0]         r_cnt;
   logic               w_pop;
   logic               w_push;

   assign w_pop   = i_pop && (r_cnt != 2'd0);
   assign w_push  = i_push && ((r_cnt != 2'd2) || w_pop);
   assign o_data  = r_mem[r_rd];
   assign o_full  = (r_cnt == 2'd2);
   assign o_empty = (r_cnt == 2'd0);

   // Clear restarts the FIFO but still keeps a same-cycle push.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd  <= 1'b0;
         r_wr  <= 1'b0;
         r_cnt <= 2'd0;
      end else if (i_clr) begin
         r_rd  <= 1'b0;
         r_wr  <= i_push;
         r_cnt <= {1'b0, i_push};
      end else begin
         if (w_push) r_wr <= ~r_wr;
         if (w_pop)  r_rd <= ~r_rd;
         r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (i_clr && i_push)
         r_mem[0] <= i_data;
      else if (!i_clr && w_push)
         r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/adc_result_sequencer.sv
// Reorders interleaved ADC samples into pixel order 0..N-1, skipping
// pixels whose sample was dropped, behind a single output register.
module adc_result_sequencer
   import readout_pkg::*;
#(
   parameter int PIXELS    = PIXELS_DEF,
   parameter int NUM_ADC   = NUM_ADC_DEF,
   parameter int ADC_WIDTH = ADC_WIDTH_DEF
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_start,
   input  logic                  overflow_clear,
   adc_result_sequencer_if.master bus,
   output logic                  frame_done,
   output logic                  overflow
);

   localparam logic [7:0] LAST_IDX = 8'(PIXELS - 1);
   localparam logic [7:0] IDLE_IDX = 8'(PIXELS);
   localparam logic [5:0] CNT_MAX  = 6'(PIXELS / NUM_ADC);

   logic [7:0]           r_exp;
   logic                 r_out_valid;
   logic [ADC_WIDTH-1:0] r_out_data;
   logic [TAG_W-1:0]     r_out_index;
   logic                 r_out_last;
   logic                 r_frame_done;
   logic                 r_overflow;

   logic [ENTRY_W-1:0]   w_head [NUM_ADC];
   logic [7:0]           w_lim  [NUM_ADC];
   logic [NUM_ADC-1:0]   w_full;
   logic [NUM_ADC-1:0]   w_empty;
   logic [NUM_ADC-1:0]   w_pop;
   logic [NUM_ADC-1:0]   w_push;
   logic [NUM_ADC-1:0]   w_drop;
   logic [1:0]           w_sel;
   logic [ENTRY_W-1:0]   w_cur;
   logic                 w_hit;
   logic                 w_can;
   logic                 w_act;
   logic                 w_emit;
   logic                 w_skip;

   for (genvar k = 0; k < NUM_ADC; k++) begin : g_ch
      localparam logic [1:0] BASE = CH_BASE[2*k +: 2];

      logic [5:0]         r_cnt;
      logic [TAG_W-1:0]   w_tag;
      logic [ENTRY_W-1:0] w_entry;

      // A strobe on frame_start is sample n=0 of the new frame.
      assign w_tag = frame_start ? {5'd0, BASE}
                   : {5'd0, BASE} + {r_cnt[4:0], 2'b00};
      assign w_entry = {bus.adc_data[ADC_WIDTH*k +: ADC_WIDTH], w_tag};
      assign w_lim[k] = {6'd0, BASE} + {r_cnt, 2'b00};
      assign w_pop[k] = w_emit && (w_sel == 2'(k));
      assign w_push[k] = bus.adc_valid[k]
                       && (frame_start || (r_cnt != CNT_MAX));
      assign w_drop[k] = bus.adc_valid[k] && !frame_start
                       && ((r_cnt == CNT_MAX) || (w_full[k] && !w_pop[k]));

      always_ff @(posedge clk) begin
         if (reset)
            r_cnt <= 6'd0;
         else if (frame_start)
            r_cnt <= {5'd0, bus.adc_valid[k]};
         else if (bus.adc_valid[k] && (r_cnt != CNT_MAX))
            r_cnt <= r_cnt + 6'd1;
      end

      adc_tag_fifo u_fifo (
         .clk     (clk),
         .reset   (reset),
         .i_clr   (frame_start),
         .i_push  (w_push[k]),
         .i_pop   (w_pop[k]),
         .i_data  (w_entry),
         .o_data  (w_head[k]),
         .o_full  (w_full[k]),
         .o_empty (w_empty[k])
      );
   end

   assign w_sel  = map_ch(r_exp[1:0]);
   assign w_cur  = w_head[w_sel];
   assign w_hit  = !w_empty[w_sel]
                && (w_cur[TAG_W-1:0] == r_exp[TAG_W-1:0]);
   assign w_can  = !r_out_valid || bus.out_ready;
   assign w_act  = !frame_start && (r_exp < IDLE_IDX);
   assign w_emit = w_act && w_hit && w_can;
   // Pixel already counted on its channel but not at the head: it was lost.
   assign w_skip = w_act && !w_hit && (r_exp < w_lim[w_sel]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_exp        <= IDLE_IDX;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_index  <= '0;
         r_out_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (frame_start) begin
         r_exp        <= 8'd0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= (w_emit || w_skip) && (r_exp == LAST_IDX);
         if (w_emit || w_skip)
            r_exp <= r_exp + 8'd1;
         if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_cur[ENTRY_W-1:TAG_W];
            r_out_index <= w_cur[TAG_W-1:0];
            r_out_last  <= (r_exp == LAST_IDX);
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_overflow <= 1'b0;
      else if (|w_drop)
         r_overflow <= 1'b1;
      else if (overflow_clear)
         r_overflow <= 1'b0;
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_index = r_out_index;
   assign bus.out_last  = r_out_last;
   assign frame_done    = r_frame_done;
   assign overflow      = r_overflow;

endmodule
